// File: rtl/mem_arbiter_if.sv
// Bundle between the arbiter, the two cache miss paths and unified main memory.
// master is the arbiter's view; slave is the caches-plus-memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORD_W = 3
);
  logic              i_miss;
  logic [ADDR_W-1:0] i_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_addr;
  logic              d_wr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] fill_data;
  logic [WORD_W-1:0] fill_word;
  logic              i_fill_valid;
  logic              i_fill_done;
  logic              d_fill_valid;
  logic              d_fill_done;
  logic              d_wr_ack;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              busy;

  modport master (
    input  i_miss, i_addr, d_miss, d_addr, d_wr, d_wdata, mem_rdata, mem_rvalid,
    output fill_data, fill_word, i_fill_valid, i_fill_done, d_fill_valid, d_fill_done,
           d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport slave (
    output i_miss, i_addr, d_miss, d_addr, d_wr, d_wdata, mem_rdata, mem_rvalid,
    input  fill_data, fill_word, i_fill_valid, i_fill_done, d_fill_valid, d_fill_done,
           d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates I-side block fills, D-side block fills and D-side write-through stores onto one
// pipelined memory. Fill words are counted off mem_rvalid, so the memory latency needs no parameter.
module mem_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.master bus
);
  localparam int WORD_W = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W  = WORD_W + 1;
  localparam int CNT_W  = WORD_W + 1;
  localparam logic [ADDR_W-1:0] BASE_MASK = ~(ADDR_W'((1 << OFF_W) - 1));

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

  state_t            state;
  logic              owner_d;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [WORD_W-1:0] rcv_cnt;
  logic              rx_fire;
  logic              rx_last;

  // Returned words only count while a fill is in flight; stray strobes elsewhere are dropped.
  assign rx_fire  = (state == FILL) && bus.mem_rvalid;
  assign rx_last  = rx_fire && (rcv_cnt == WORD_W'(WORDS_PER_BLOCK - 1));
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner_d       <= 1'b0;
      base          <= '0;
      issue_cnt     <= '0;
      rcv_cnt       <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.d_wr_ack  <= 1'b0;
    end else begin
      bus.mem_en    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.d_wr_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.d_wr) begin
            state         <= WRITE;
            bus.mem_en    <= 1'b1;
            bus.mem_wr    <= 1'b1;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.d_wr_ack  <= 1'b1;
          end else if (bus.d_miss || bus.i_miss) begin
            // The first read goes out with the accept so word 0 is on the bus the next cycle.
            state        <= FILL;
            owner_d      <= bus.d_miss;
            base         <= (bus.d_miss ? bus.d_addr : bus.i_addr) & BASE_MASK;
            bus.mem_en   <= 1'b1;
            bus.mem_addr <= (bus.d_miss ? bus.d_addr : bus.i_addr) & BASE_MASK;
            issue_cnt    <= CNT_W'(1);
            rcv_cnt      <= '0;
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        FILL: begin
          if (issue_cnt < CNT_W'(WORDS_PER_BLOCK)) begin
            bus.mem_en   <= 1'b1;
            bus.mem_addr <= base + (ADDR_W'(issue_cnt) << 1);
            issue_cnt    <= issue_cnt + CNT_W'(1);
          end
          if (rx_fire) begin
            rcv_cnt <= rcv_cnt + WORD_W'(1);
          end
          if (rx_last) begin
            state     <= IDLE;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.fill_data    = '0;
    bus.fill_word    = '0;
    bus.i_fill_valid = 1'b0;
    bus.i_fill_done  = 1'b0;
    bus.d_fill_valid = 1'b0;
    bus.d_fill_done  = 1'b0;
    if (rx_fire) begin
      bus.fill_data = bus.mem_rdata;
      bus.fill_word = rcv_cnt;
      if (owner_d) begin
        bus.d_fill_valid = 1'b1;
        bus.d_fill_done  = rx_last;
      end else begin
        bus.i_fill_valid = 1'b1;
        bus.i_fill_done  = rx_last;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, hand-written corner sequences and a random
// phase, all scored each cycle against a transaction-timeline model of the arbiter.
module tb_mem_arbiter;
  localparam int WPB = 8;
  localparam int LAT = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam logic [AW-1:0] BMASK = ~(AW'(2 * WPB - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .WORD_W(3)) bus ();

  mem_arbiter #(.WORDS_PER_BLOCK(WPB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Pipelined memory: each word is a seed plus its index within the block.
  logic [DW-1:0] data_seed = '0;
  logic          spur      = 1'b0;
  logic [DW-1:0] spur_data = '0;
  logic          pv [LAT];
  logic [DW-1:0] pd [LAT];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return data_seed + DW'((a >> 1) & 7);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      pv[0] <= bus.mem_en && !bus.mem_wr;
      pd[0] <= mem_word(bus.mem_addr);
    end
  end

  assign bus.mem_rvalid = pv[LAT-1] | spur;
  assign bus.mem_rdata  = spur ? spur_data : pd[LAT-1];

  typedef struct packed {
    logic [DW-1:0] fill_data;
    logic [2:0]    fill_word;
    logic          i_fv;
    logic          i_fd;
    logic          d_fv;
    logic          d_fd;
    logic          ack;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
  } out_t;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] seed;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;
    int            cycles;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cur_cyc = 0;
  out_t cur;
  logic last_i_done = 1'b0;
  logic last_d_done = 1'b0;
  logic last_ack    = 1'b0;

  // Model: a transaction is a kind plus its accept cycle; every output is a function of the offset.
  int            m_kind = 0;
  logic          m_owner_d = 1'b0;
  int            m_start = 0;
  logic [AW-1:0] m_base = '0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;

  function automatic out_t model_expect();
    out_t e;
    int off;
    int w;
    e   = '0;
    off = cyc - m_start;
    if (m_kind == 2) begin
      e.busy = 1'b1;
      if (off >= 1 && off <= WPB) begin
        e.mem_en   = 1'b1;
        e.mem_addr = m_base + AW'(2 * (off - 1));
      end
      if (off >= 1 + LAT && off <= LAT + WPB) begin
        w           = off - 1 - LAT;
        e.fill_data = data_seed + DW'(w);
        e.fill_word = 3'(w);
        if (m_owner_d) begin
          e.d_fv = 1'b1;
          e.d_fd = (off == LAT + WPB);
        end else begin
          e.i_fv = 1'b1;
          e.i_fd = (off == LAT + WPB);
        end
      end
    end else if (m_kind == 1) begin
      e.busy      = 1'b1;
      e.mem_en    = 1'b1;
      e.mem_wr    = 1'b1;
      e.mem_addr  = m_waddr;
      e.mem_wdata = m_wdata;
      e.ack       = 1'b1;
    end
    return e;
  endfunction

  task automatic model_advance();
    if (rst) begin
      m_kind = 0;
    end else if (m_kind == 2) begin
      if (cyc - m_start == LAT + WPB) m_kind = 0;
    end else if (m_kind == 1) begin
      m_kind = 0;
    end else if (bus.d_wr) begin
      m_kind  = 1;
      m_start = cyc;
      m_waddr = bus.d_addr;
      m_wdata = bus.d_wdata;
    end else if (bus.d_miss || bus.i_miss) begin
      m_kind    = 2;
      m_start   = cyc;
      m_owner_d = bus.d_miss;
      m_base    = (bus.d_miss ? bus.d_addr : bus.i_addr) & BMASK;
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.fill_data = bus.fill_data;
    o.fill_word = bus.fill_word;
    o.i_fv      = bus.i_fill_valid;
    o.i_fd      = bus.i_fill_done;
    o.d_fv      = bus.d_fill_valid;
    o.d_fd      = bus.d_fill_done;
    o.ack       = bus.d_wr_ack;
    o.mem_en    = bus.mem_en;
    o.mem_wr    = bus.mem_wr;
    o.mem_addr  = bus.mem_addr;
    o.mem_wdata = bus.mem_wdata;
    o.busy      = bus.busy;
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One clock: score the whole output bundle mid-cycle, then let requesters drop on done/ack.
  task automatic applyStimulus();
    out_t e;
    @(negedge clk);
    e       = model_expect();
    cur     = sample();
    cur_cyc = cyc;
    checks++;
    if (cur !== e) begin
      errors++;
      $display("[TB] FAIL cycle %0d outputs: got %h expected %h", cyc, cur, e);
    end
    last_i_done = cur.i_fd;
    last_d_done = cur.d_fd;
    last_ack    = cur.ack;
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
    if (last_i_done) bus.i_miss = 1'b0;
    if (last_d_done) bus.d_miss = 1'b0;
    if (last_ack)    bus.d_wr   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global timeout");
    $fatal(1);
  end

  vec_t vecs[5];
  int   n;
  int   d_cyc;
  int   i_cyc;
  int   ack_cyc;
  int   ack_cnt;
  int   pulses;
  logic done;
  logic got_first;
  logic [AW-1:0] first_a;
  logic [AW-1:0] last_a;
  logic [DW-1:0] last_d;

  initial begin
    vecs[0] = '{0, 16'h1236, 16'h0000, 16'h00A0, 16'h1230, 16'h123E, 16'h00A7, 12};
    vecs[1] = '{1, 16'hFFFA, 16'h0000, 16'h0010, 16'hFFF0, 16'hFFFE, 16'h0017, 12};
    vecs[2] = '{2, 16'h00F2, 16'hBEEF, 16'h0000, 16'h00F2, 16'h00F2, 16'hBEEF, 1};
    vecs[3] = '{0, 16'h0001, 16'h0000, 16'h0300, 16'h0000, 16'h000E, 16'h0307, 12};
    vecs[4] = '{1, 16'h8011, 16'h0000, 16'hFFF9, 16'h8010, 16'h801E, 16'h0000, 12};

    bus.i_miss = 1'b0; bus.i_addr = '0; bus.d_miss = 1'b0; bus.d_addr = '0;
    bus.d_wr = 1'b0; bus.d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus();
    applyStimulus();
    checkOutput("reset busy", 32'(cur.busy), 32'd0);
    checkOutput("reset mem_en", 32'(cur.mem_en), 32'd0);
    rst = 1'b0;
    applyStimulus();

    for (int v = 0; v < 5; v++) begin
      data_seed = vecs[v].seed;
      if (vecs[v].kind == 0) begin
        bus.i_addr = vecs[v].addr; bus.i_miss = 1'b1;
      end else if (vecs[v].kind == 1) begin
        bus.d_addr = vecs[v].addr; bus.d_miss = 1'b1;
      end else begin
        bus.d_addr = vecs[v].addr; bus.d_wdata = vecs[v].wdata; bus.d_wr = 1'b1;
      end
      n = 0; done = 1'b0; got_first = 1'b0; first_a = '0; last_a = '0; last_d = '0;
      applyStimulus();
      while (!done && n < 40) begin
        applyStimulus();
        n++;
        if (cur.mem_en) begin
          if (!got_first) first_a = cur.mem_addr;
          got_first = 1'b1;
          last_a    = cur.mem_addr;
        end
        if (vecs[v].kind == 2 && cur.ack) begin
          done = 1'b1; last_d = cur.mem_wdata;
        end
        if (vecs[v].kind != 2 && (cur.i_fd || cur.d_fd)) begin
          done = 1'b1; last_d = cur.fill_data;
        end
      end
      checkOutput($sformatf("vec%0d completed", v), 32'(done), 32'd1);
      checkOutput($sformatf("vec%0d latency", v), 32'(n), 32'(vecs[v].cycles));
      checkOutput($sformatf("vec%0d first addr", v), 32'(first_a), 32'(vecs[v].first_addr));
      checkOutput($sformatf("vec%0d last addr", v), 32'(last_a), 32'(vecs[v].last_addr));
      checkOutput($sformatf("vec%0d last data", v), 32'(last_d), 32'(vecs[v].last_data));
    end

    // Simultaneous misses: D first, I accepted after a single idle cycle.
    data_seed = 16'h0200;
    bus.d_addr = 16'h0040; bus.d_miss = 1'b1;
    bus.i_addr = 16'h0080; bus.i_miss = 1'b1;
    d_cyc = -100; i_cyc = 0;
    for (int k = 0; k < 60 && i_cyc == 0; k++) begin
      applyStimulus();
      if (cur.d_fd) d_cyc = cur_cyc;
      if (cur.i_fd) i_cyc = cur_cyc;
    end
    checkOutput("simul D then I gap", 32'(i_cyc - d_cyc), 32'd13);

    // Store arriving during an I fill waits for done plus one idle cycle.
    data_seed = 16'h0400;
    bus.i_addr = 16'h0300; bus.i_miss = 1'b1;
    repeat (3) applyStimulus();
    bus.d_addr = 16'h00F2; bus.d_wdata = 16'hBEEF; bus.d_wr = 1'b1;
    i_cyc = -100; ack_cyc = 0; ack_cnt = 0; last_a = '0; last_d = '0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus();
      if (cur.i_fd) i_cyc = cur_cyc;
      if (cur.ack) begin
        ack_cyc = cur_cyc; ack_cnt++; last_a = cur.mem_addr; last_d = cur.mem_wdata;
      end
    end
    checkOutput("store after fill gap", 32'(ack_cyc - i_cyc), 32'd2);
    checkOutput("store ack count", 32'(ack_cnt), 32'd1);
    checkOutput("store addr", 32'(last_a), 32'h00F2);
    checkOutput("store data", 32'(last_d), 32'hBEEF);

    // Reset three cycles into a D fill, then a clean I fill.
    data_seed = 16'h0500;
    bus.d_addr = 16'h1234; bus.d_miss = 1'b1;
    repeat (4) applyStimulus();
    rst = 1'b1; bus.d_miss = 1'b0;
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    checkOutput("post-reset busy", 32'(cur.busy), 32'd0);
    checkOutput("post-reset quiet", 32'(|cur), 32'd0);
    data_seed = 16'h0700;
    bus.i_addr = 16'h4446; bus.i_miss = 1'b1;
    done = 1'b0; n = 0; last_d = '0;
    applyStimulus();
    while (!done && n < 40) begin
      applyStimulus();
      n++;
      if (cur.i_fd) begin
        done = 1'b1; last_d = cur.fill_data;
      end
    end
    checkOutput("refill latency", 32'(n), 32'd12);
    checkOutput("refill last data", 32'(last_d), 32'h0707);

    // Stray read-valid strobes while idle must not produce fill pulses.
    applyStimulus();
    pulses = 0;
    spur = 1'b1;
    for (int k = 0; k < 3; k++) begin
      spur_data = DW'(16'h1111 * (k + 1));
      applyStimulus();
      pulses += int'(cur.i_fv) + int'(cur.d_fv) + int'(cur.i_fd) + int'(cur.d_fd);
    end
    spur = 1'b0;
    checkOutput("spurious fill pulses", 32'(pulses), 32'd0);
    checkOutput("spurious busy", 32'(cur.busy), 32'd0);

    // Random requesters with address churn on the active owner and stray strobes outside fills.
    for (int t = 0; t < 3000; t++) begin
      if (m_kind == 0) data_seed = DW'($urandom);
      if (!bus.i_miss && !last_i_done && $urandom_range(0, 3) == 0) begin
        bus.i_addr = AW'($urandom); bus.i_miss = 1'b1;
      end
      if (!bus.d_miss && !bus.d_wr && !last_d_done && !last_ack && $urandom_range(0, 3) == 0) begin
        bus.d_addr = AW'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          bus.d_wdata = DW'($urandom); bus.d_wr = 1'b1;
        end else begin
          bus.d_miss = 1'b1;
        end
      end
      if (m_kind == 2) begin
        if (m_owner_d) bus.d_addr = AW'($urandom);
        else           bus.i_addr = AW'($urandom);
      end
      spur      = (m_kind != 2) && ($urandom_range(0, 5) == 0);
      spur_data = DW'($urandom);
      applyStimulus();
    end
    spur = 1'b0;
    for (int k = 0; k < 40 && (bus.i_miss || bus.d_miss || bus.d_wr); k++) applyStimulus();
    bus.i_miss = 1'b0; bus.d_miss = 1'b0; bus.d_wr = 1'b0;
    repeat (3) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
